// File: rtl/load_pkg.sv
// Shared encodings and helpers for the load-data alignment stage.
package load_pkg;

  localparam int DATA_W = 32;

  localparam logic LOAD_WORD = 1'b0;
  localparam logic LOAD_BYTE = 1'b1;

  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;

  function automatic logic [DATA_W-1:0] sign_ext(input logic [7:0] b);
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

endpackage

// File: rtl/byte_extract.sv
// Combinational byte picker: selects one byte of a word by offset and sign-extends it.
module byte_extract
  import load_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] ext
);

  logic [7:0] sel_byte;

  // An unknown offset falls to the default so X reaches the result unmasked.
  always_comb begin
    sel_byte = '0;
    case (offset)
      OFF_B0:  sel_byte = word[7:0];
      OFF_B1:  sel_byte = word[15:8];
      OFF_B2:  sel_byte = word[23:16];
      OFF_B3:  sel_byte = word[31:24];
      default: sel_byte = 'x;
    endcase
    ext = sign_ext(sel_byte);
  end

endmodule

// File: rtl/load_block.sv
// Load-data alignment stage: word or sign-extended byte load, registered for write-back.
// No handshake: every rising edge samples the inputs and the result appears one cycle later.
module load_block
  import load_pkg::*;
#(
  parameter int DATA_W_P = DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W_P-1:0] Load_Memory,
  input  logic                Load_Select,
  input  logic [1:0]          Offset,
  output logic [DATA_W_P-1:0] Load_data
);

  logic [DATA_W-1:0] byte_ext;
  logic [DATA_W-1:0] load_next;

  byte_extract u_byte_extract (
    .word   (Load_Memory),
    .offset (Offset),
    .ext    (byte_ext)
  );

  // Unknown select must propagate rather than merge matching bits of both sources.
  always_comb begin
    load_next = '0;
    case (Load_Select)
      LOAD_WORD: load_next = Load_Memory;
      LOAD_BYTE: load_next = byte_ext;
      default:   load_next = 'x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) Load_data <= '0;
    else     Load_data <= load_next;
  end

endmodule

// File: tb/tb_load_block.sv
// Randomized and directed bench for load_block against a behavioural load model.
module tb_load_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Load_Memory;
  logic        Load_Select;
  logic [1:0]  Offset;
  logic [31:0] Load_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_block dut (
    .clk         (clk),
    .rst         (rst),
    .Load_Memory (Load_Memory),
    .Load_Select (Load_Select),
    .Offset      (Offset),
    .Load_data   (Load_data)
  );

  // Reference: word passes through; byte is taken as a signed value in -128..127.
  function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic sel,
                                           input logic [1:0] off);
    int v;
    if (!sel) return mem;
    v = int'((mem / (32'd1 << (8 * int'(off)))) % 32'd256);
    if (v > 127) v = v - 256;
    return 32'(v);
  endfunction

  // Apply inputs after an edge, then wait to 1 ns past the next edge where the result shows.
  task automatic drive(input logic [31:0] mem, input logic sel, input logic [1:0] off,
                       input logic r);
    rst         = r;
    Load_Memory = mem;
    Load_Select = sel;
    Offset      = off;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(32'hA14BC5F3, 1'b1, 2'd1, 1'b1);
      checks++;
      if (Load_data !== 32'h0) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h want 00000000", i, Load_data);
      end
    end
    drive(32'hA14BC5F3, 1'b0, 2'd0, 1'b0);
    checks++;
    if (Load_data !== 32'hA14BC5F3) begin
      errors++;
      $display("FAIL reset_release: got %h want a14bc5f3", Load_data);
    end
  endtask

  task automatic test_word_offset;
    for (int o = 0; o < 4; o++) begin
      drive(32'hA14BC5F3, 1'b0, 2'(o), 1'b0);
      checks++;
      if (Load_data !== 32'hA14BC5F3) begin
        errors++;
        $display("FAIL word_offset off=%0d: got %h want a14bc5f3", o, Load_data);
      end
    end
  endtask

  task automatic test_byte_sweep;
    logic [31:0] exp_tab [4];
    exp_tab = '{32'hFFFFFFF3, 32'hFFFFFFC5, 32'h0000004B, 32'hFFFFFFA1};
    for (int o = 0; o < 4; o++) begin
      drive(32'hA14BC5F3, 1'b1, 2'(o), 1'b0);
      checks++;
      if (Load_data !== exp_tab[o]) begin
        errors++;
        $display("FAIL byte_sweep off=%0d: got %h want %h", o, Load_data, exp_tab[o]);
      end
    end
  endtask

  task automatic test_sign_boundary;
    logic [31:0] exp_tab [4];
    exp_tab = '{32'hFFFFFF80, 32'h00000000, 32'h0000007F, 32'hFFFFFF80};
    for (int o = 0; o < 4; o++) begin
      drive(32'h807F0080, 1'b1, 2'(o), 1'b0);
      checks++;
      if (Load_data !== exp_tab[o]) begin
        errors++;
        $display("FAIL sign_boundary off=%0d: got %h want %h", o, Load_data, exp_tab[o]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] mem;
    logic [1:0]  off;
    logic [31:0] exp;
    for (int i = 0; i < 24; i++) begin
      mem = $urandom;
      off = 2'($urandom_range(0, 3));
      exp = ref_load(mem, 1'(i % 2), off);
      drive(mem, 1'(i % 2), off, 1'b0);
      checks++;
      if (Load_data !== exp) begin
        errors++;
        $display("FAIL back_to_back i=%0d: got %h want %h", i, Load_data, exp);
      end
    end
  endtask

  task automatic test_midstream_reset;
    logic [31:0] exp_tab [4];
    exp_tab = '{32'hFFFFFFF3, 32'h00000000, 32'h0000004B, 32'hFFFFFFA1};
    for (int o = 0; o < 4; o++) begin
      drive(32'hA14BC5F3, 1'b1, 2'(o), o == 1);
      checks++;
      if (Load_data !== exp_tab[o]) begin
        errors++;
        $display("FAIL midstream_reset off=%0d: got %h want %h", o, Load_data, exp_tab[o]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] mem;
    logic        sel;
    logic [1:0]  off;
    logic        r;
    logic [31:0] exp;
    for (int i = 0; i < 300; i++) begin
      mem = $urandom;
      sel = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      r   = ($urandom_range(0, 15) == 0);
      exp = r ? 32'h0 : ref_load(mem, sel, off);
      drive(mem, sel, off, r);
      checks++;
      if (Load_data !== exp) begin
        errors++;
        $display("FAIL random i=%0d mem=%h sel=%0d off=%0d rst=%0d: got %h want %h",
                 i, mem, sel, off, r, Load_data, exp);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    Load_Memory = '0;
    Load_Select = 1'b0;
    Offset      = 2'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_word_offset();
    test_byte_sweep();
    test_sign_boundary();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
